uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Accepts a parallel byte through a valid/ready handshake and drives the shift-register serializer's load/enable controls.
- Generates start, optional parity and stop bits, and multiplexes them with the serializer bit stream onto the line.
- Sits between the host-side TX interface and the pad; owns busy/ready and frame timing, one bit per clk1 cycle (clk1 is the bit-rate clock).

---
 rtl/uart_tx_ctrl_if.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmit controller.
// Parity configuration travels with the byte and is captured at accept.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_ready;
    logic                  par_en;
    logic                  par_typ;

    modport master (
        output data_valid,
        output p_data,
        output par_en,
        output par_typ,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  p_data,
        input  par_en,
        input  par_typ,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data (from external serializer), optional parity, stop.
// One line bit per clk1 cycle; tx_out is registered and always holds the bit of the current state.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk1,
    input  logic           rst,
    uart_tx_ctrl_if.slave  host,
    output logic           ser_load,
    output logic           ser_en,
    input  logic           ser_bit,
    input  logic           ser_done,
    output logic           tx_out,
    output logic           busy,
    output logic           frame_done,
    output logic           ser_err
);

    localparam int               CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             stop_cnt, stop_cnt_nxt;
    logic             par_en_q, parity_q;
    logic             tx_nxt, accept, last_bit, last_stop, err_set;

    always_comb begin
        last_bit        = (bit_cnt == BIT_LAST);
        last_stop       = (state == STOP) && (stop_cnt == STOP_LAST);
        host.data_ready = (state == IDLE) || last_stop;
        accept          = host.data_valid && host.data_ready && !rst;
        ser_load        = accept;
        ser_en          = (state == START) || ((state == DATA) && !last_bit);
        frame_done      = last_stop && !rst;
        err_set         = (state == DATA) && (last_bit ? !ser_done : ser_done);

        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = 1'b1;

        // tx_nxt is the line level for the state being entered next cycle
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                state_nxt   = DATA;
                bit_cnt_nxt = '0;
                tx_nxt      = ser_bit;
            end
            DATA: begin
                if (last_bit) begin
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = 1'b0;
                    if (par_en_q) begin
                        state_nxt = PARITY;
                        tx_nxt    = parity_q;
                    end else begin
                        state_nxt = STOP;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    tx_nxt      = ser_bit;
                end
            end
            PARITY: begin
                state_nxt    = STOP;
                stop_cnt_nxt = 1'b0;
            end
            STOP: begin
                if (last_stop) begin
                    stop_cnt_nxt = 1'b0;
                    if (accept) begin
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    stop_cnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            ser_err  <= 1'b0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            tx_out   <= tx_nxt;
            busy     <= (state_nxt != IDLE);
            if (err_set) begin
                ser_err <= 1'b1;
            end
            if (accept) begin
                par_en_q <= host.par_en;
                parity_q <= (^host.p_data) ^ host.par_typ;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a shift-register serializer model feeds the DUT,
// and a scoreboard queue of expected line bits is compared against tx_out every cycle.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) host ();

    logic ser_load, ser_en, ser_bit, ser_done;
    logic tx_out, busy, frame_done, ser_err;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .host       (host),
        .ser_load   (ser_load),
        .ser_en     (ser_en),
        .ser_bit    (ser_bit),
        .ser_done   (ser_done),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .ser_err    (ser_err)
    );

    // Serializer model: done_mode 0 = correct, 1 = ser_done stuck low, 2 = stuck high
    logic [DW-1:0] sreg = '0;
    int            shift_cnt = 0;
    int            done_mode = 0;

    always @(posedge clk1) begin
        if (ser_load) begin
            sreg      <= host.p_data;
            shift_cnt <= 0;
        end else if (ser_en) begin
            sreg      <= sreg >> 1;
            shift_cnt <= shift_cnt + 1;
        end
    end

    assign ser_bit  = sreg[0];
    assign ser_done = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : (shift_cnt == DW);

    typedef struct packed {
        logic tx;
        logic fd;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
        logic       pbit;
        int         len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   fd_log[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cycle = 0;
    bit   idle_chk = 1'b0;
    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk1) cycle++;

    always @(negedge clk1) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_output("tx_out", 32'(tx_out), 32'(mon_e.tx));
            check_output("frame_done", 32'(frame_done), 32'(mon_e.fd));
        end else if (idle_chk) begin
            check_output("idle_tx_out", 32'(tx_out), 32'd1);
            check_output("idle_frame_done", 32'(frame_done), 32'd0);
            check_output("idle_busy", 32'(busy), 32'd0);
        end
        if (frame_done) fd_log.push_back(cycle);
    end

    function automatic void push_frame(input logic [7:0] d, input logic pen, input logic pbit);
        sb.push_back({1'b0, 1'b0});
        for (int i = 0; i < DW; i++) sb.push_back({d[i], 1'b0});
        if (pen) sb.push_back({pbit, 1'b0});
        sb.push_back({1'b1, 1'b1});
    endfunction

    // Called at the drive point (posedge+2); returns at the drive point of the cycle after accept
    task automatic apply_stimulus(input logic [7:0] d, input logic pen, input logic ptyp, input logic pbit);
        int guard;
        host.data_valid = 1'b1;
        host.p_data     = d;
        host.par_en     = pen;
        host.par_typ    = ptyp;
        #1;
        guard = 0;
        while (!host.data_ready && guard < 40) begin
            @(posedge clk1);
            #3;
            guard++;
        end
        check_output("ser_load_at_accept", 32'(ser_load), 32'd1);
        @(posedge clk1);
        push_frame(d, pen, pbit);
        #2;
    endtask

    task automatic wait_frame(input int exp_len);
        int n;
        n = 1;
        while (!frame_done && n < 40) begin
            @(posedge clk1);
            #2;
            n++;
        end
        check_output("frame_len", 32'(n), 32'(exp_len));
        @(posedge clk1);
        #2;
        check_output("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
        vecs[5] = '{8'h07, 1'b1, 1'b0, 1'b1, 11};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 10};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};

        host.data_valid = 1'b0;
        host.p_data     = '0;
        host.par_en     = 1'b0;
        host.par_typ    = 1'b0;

        repeat (2) @(posedge clk1);
        #2;
        check_output("reset_tx_out", 32'(tx_out), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_data_ready", 32'(host.data_ready), 32'd1);
        check_output("reset_ser_err", 32'(ser_err), 32'd0);
        rst      = 1'b0;
        idle_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk1);
            #2;
            check_output("idle_data_ready", 32'(host.data_ready), 32'd1);
            check_output("idle_ser_en", 32'(ser_en), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].pen, vecs[i].ptyp, vecs[i].pbit);
            host.data_valid = 1'b0;
            wait_frame(vecs[i].len);
        end
        check_output("ser_err_normal", 32'(ser_err), 32'd0);

        // Back-to-back frames with data_valid held high
        fd_log.delete();
        apply_stimulus(8'h0F, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'hF0, 1'b0, 1'b0, 1'b0);
        host.data_valid = 1'b0;
        wait_frame(10);
        check_output("b2b_fd_count", 32'(fd_log.size()), 32'd2);
        if (fd_log.size() >= 2) check_output("b2b_fd_spacing", 32'(fd_log[1] - fd_log[0]), 32'd10);

        // Reset during data bit 3 drops the frame
        fd_log.delete();
        apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0);
        host.data_valid = 1'b0;
        repeat (4) begin
            @(posedge clk1);
            #2;
        end
        rst = 1'b1;
        @(posedge clk1);
        sb.delete();
        sb.push_back({1'b1, 1'b0});
        #2;
        check_output("midreset_busy", 32'(busy), 32'd0);
        check_output("midreset_tx_out", 32'(tx_out), 32'd1);
        check_output("midreset_data_ready", 32'(host.data_ready), 32'd1);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk1);
            #2;
        end
        check_output("midreset_no_frame_done", 32'(fd_log.size()), 32'd0);
        apply_stimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        host.data_valid = 1'b0;
        wait_frame(11);

        // Reset and data_valid together: reset wins
        rst             = 1'b1;
        host.data_valid = 1'b1;
        host.p_data     = 8'h99;
        #1;
        check_output("rst_valid_ser_load", 32'(ser_load), 32'd0);
        @(posedge clk1);
        #2;
        check_output("rst_valid_busy", 32'(busy), 32'd0);
        host.data_valid = 1'b0;
        rst             = 1'b0;
        @(posedge clk1);
        #2;

        // ser_done never asserted: error appears after the last data cycle
        done_mode = 1;
        apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        host.data_valid = 1'b0;
        repeat (8) begin
            @(posedge clk1);
            #2;
        end
        check_output("ser_err_before_last", 32'(ser_err), 32'd0);
        @(posedge clk1);
        #2;
        check_output("ser_err_after_last", 32'(ser_err), 32'd1);
        repeat (4) begin
            @(posedge clk1);
            #2;
        end
        check_output("ser_err_sticky", 32'(ser_err), 32'd1);
        done_mode = 0;
        rst       = 1'b1;
        @(posedge clk1);
        #2;
        rst = 1'b0;
        check_output("ser_err_cleared", 32'(ser_err), 32'd0);

        // ser_done stuck high: early completion flagged
        done_mode = 2;
        apply_stimulus(8'h07, 1'b1, 1'b0, 1'b1);
        host.data_valid = 1'b0;
        wait_frame(11);
        check_output("ser_err_early", 32'(ser_err), 32'd1);
        done_mode = 0;
        rst       = 1'b1;
        @(posedge clk1);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk1);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
